// File: rtl/mem_pkg.sv
// Shared types and constants for the BaseRAM request path.
// Used by the request arbiter/sequencer and its round-robin sub-arbiter.
package mem_pkg;

  localparam int RD_LAT_DEF = 3;
  localparam int WR_LAT_DEF = 2;
  localparam int SRAM_AW    = 20;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; gnt_o[0] = fetch, gnt_o[1] = data.
// The last-winner flag only moves on an accepted grant.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_if_i,
  input  logic       req_d_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  port_e last_r;
  logic [1:0] gnt_s;

  // grant selection: lone requester wins, contention goes to the port that lost last time
  always_comb begin
    gnt_s = 2'b00;
    if (req_if_i && req_d_i) begin
      if (last_r == PORT_D) begin
        gnt_s = 2'b01;
      end else begin
        gnt_s = 2'b10;
      end
    end else if (req_if_i) begin
      gnt_s = 2'b01;
    end else if (req_d_i) begin
      gnt_s = 2'b10;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // last-winner register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r <= PORT_D;
    end else if (accept_i && (gnt_s != 2'b00)) begin
      last_r <= gnt_s[1] ? PORT_D : PORT_IF;
    end else begin
      last_r <= last_r;
    end
  end

  assign gnt_o = gnt_s;

endmodule

// File: rtl/sram_req_arb.sv
// Fetch/load-store request arbiter and strobe sequencer feeding the BaseRAM controller.
// One transaction in flight: IDLE -> ISSUE -> WAIT x LAT -> RESP; zero-be writes skip to RESP.
module sram_req_arb
  import mem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int WR_LAT = WR_LAT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic               if_ready_o,
  output logic               if_rvalid_o,
  output logic [31:0]        if_rdata_o,
  input  logic               d_req_i,
  input  logic               d_we_i,
  input  logic [31:0]        d_addr_i,
  input  logic [31:0]        d_wdata_i,
  input  logic [3:0]         d_be_i,
  output logic               d_ready_o,
  output logic               d_rvalid_o,
  output logic [31:0]        d_rdata_o,
  output logic               mem_re_n_o,
  output logic               mem_we_n_o,
  output logic [SRAM_AW-1:0] mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  output logic [3:0]         mem_be_n_o,
  input  logic [31:0]        mem_rdata_i
);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  port_e              port_r;
  logic               we_r;
  logic               re_n_r;
  logic               we_n_r;
  logic [SRAM_AW-1:0] addr_r;
  logic [31:0]        wdata_r;
  logic [3:0]         be_n_r;
  logic               if_rvalid_r;
  logic               d_rvalid_r;
  logic [31:0]        if_rdata_r;
  logic [31:0]        d_rdata_r;

  logic [1:0] gnt_s;
  logic       idle_s;
  logic       accept_s;
  logic       win_d_s;
  logic       win_we_s;
  logic       zero_be_s;
  logic       unused_s;

  // address bits outside the 4 MiB word window are deliberately dropped
  assign unused_s = ^{if_addr_i[31:22], if_addr_i[1:0], d_addr_i[31:22], d_addr_i[1:0]};

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_if_i (if_req_i),
    .req_d_i  (d_req_i),
    .accept_i (accept_s),
    .gnt_o    (gnt_s)
  );

  // acceptance decode; ready is combinational so the requester sees it in the request cycle
  always_comb begin
    idle_s    = (state_r == ST_IDLE);
    accept_s  = 1'b0;
    win_d_s   = gnt_s[1];
    win_we_s  = gnt_s[1] & d_we_i;
    zero_be_s = 1'b0;
    if (idle_s) begin
      accept_s  = if_req_i | d_req_i;
      zero_be_s = win_we_s & (d_be_i == 4'b0000);
    end else begin
      accept_s  = 1'b0;
      zero_be_s = 1'b0;
    end
  end

  assign if_ready_o = idle_s & gnt_s[0];
  assign d_ready_o  = idle_s & gnt_s[1];

  // transaction sequencer with registered strobes, payload and responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      port_r      <= PORT_IF;
      we_r        <= 1'b0;
      re_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      addr_r      <= {SRAM_AW{1'b0}};
      wdata_r     <= 32'h0000_0000;
      be_n_r      <= 4'b1111;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      d_rdata_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            port_r  <= win_d_s ? PORT_D : PORT_IF;
            we_r    <= win_we_s;
            addr_r  <= win_d_s ? d_addr_i[21:2] : if_addr_i[21:2];
            wdata_r <= win_we_s ? d_wdata_i : 32'h0000_0000;
            be_n_r  <= win_we_s ? ~d_be_i : 4'b0000;
            if (zero_be_s) begin
              state_r    <= ST_RESP;
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= 32'h0000_0000;
            end else begin
              state_r <= ST_ISSUE;
              re_n_r  <= win_we_s;
              we_n_r  <= ~win_we_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          re_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          cnt_r   <= we_r ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= ST_RESP;
            if (port_r == PORT_D) begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= we_r ? 32'h0000_0000 : mem_rdata_i;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= mem_rdata_i;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if_rvalid_r <= 1'b0;
          d_rvalid_r  <= 1'b0;
          if_rdata_r  <= 32'h0000_0000;
          d_rdata_r   <= 32'h0000_0000;
          state_r     <= ST_IDLE;
        end
        default: begin
          re_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rvalid_o = if_rvalid_r;
  assign if_rdata_o  = if_rdata_r;
  assign d_rvalid_o  = d_rvalid_r;
  assign d_rdata_o   = d_rdata_r;
  assign mem_re_n_o  = re_n_r;
  assign mem_we_n_o  = we_n_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign mem_be_n_o  = be_n_r;

endmodule

// File: tb/tb_sram_req_arb.sv
// Directed bench for sram_req_arb: default-latency instance plus an RD_LAT=1 instance.
module tb_sram_req_arb;

  logic clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  logic        rst_n_s;
  logic        if_req_s, d_req_s, d_we_s;
  logic [31:0] if_addr_s, d_addr_s, d_wdata_s, mem_rdata_s;
  logic [3:0]  d_be_s;
  logic        if_ready_s, if_rvalid_s, d_ready_s, d_rvalid_s, re_n_s, we_n_s;
  logic [31:0] if_rdata_s, d_rdata_s, mem_wdata_s;
  logic [19:0] mem_addr_s;
  logic [3:0]  mem_be_n_s;

  logic        b_if_req_s;
  logic [31:0] b_if_addr_s, b_mem_rdata_s;
  logic        b_if_ready_s, b_if_rvalid_s, b_d_ready_s, b_d_rvalid_s, b_re_n_s, b_we_n_s;
  logic [31:0] b_if_rdata_s, b_d_rdata_s, b_mem_wdata_s;
  logic [19:0] b_mem_addr_s;
  logic [3:0]  b_mem_be_n_s;

  int n_total = 0;
  int n_bad   = 0;

  sram_req_arb dut (
    .clk_i(clk_s), .rst_ni(rst_n_s),
    .if_req_i(if_req_s), .if_addr_i(if_addr_s), .if_ready_o(if_ready_s),
    .if_rvalid_o(if_rvalid_s), .if_rdata_o(if_rdata_s),
    .d_req_i(d_req_s), .d_we_i(d_we_s), .d_addr_i(d_addr_s), .d_wdata_i(d_wdata_s),
    .d_be_i(d_be_s), .d_ready_o(d_ready_s), .d_rvalid_o(d_rvalid_s), .d_rdata_o(d_rdata_s),
    .mem_re_n_o(re_n_s), .mem_we_n_o(we_n_s), .mem_addr_o(mem_addr_s),
    .mem_wdata_o(mem_wdata_s), .mem_be_n_o(mem_be_n_s), .mem_rdata_i(mem_rdata_s)
  );

  sram_req_arb #(.RD_LAT(1), .WR_LAT(1)) dut_fast (
    .clk_i(clk_s), .rst_ni(rst_n_s),
    .if_req_i(b_if_req_s), .if_addr_i(b_if_addr_s), .if_ready_o(b_if_ready_s),
    .if_rvalid_o(b_if_rvalid_s), .if_rdata_o(b_if_rdata_s),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(32'h0000_0000), .d_wdata_i(32'h0000_0000),
    .d_be_i(4'b0000), .d_ready_o(b_d_ready_s), .d_rvalid_o(b_d_rvalid_s), .d_rdata_o(b_d_rdata_s),
    .mem_re_n_o(b_re_n_s), .mem_we_n_o(b_we_n_s), .mem_addr_o(b_mem_addr_s),
    .mem_wdata_o(b_mem_wdata_s), .mem_be_n_o(b_mem_be_n_s), .mem_rdata_i(b_mem_rdata_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  // one transaction; caller is just after a posedge with the DUT idle
  task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [19:0] exp_addr, input logic [3:0] exp_be_n,
                         input logic [31:0] rdata, input int resp_cyc);
    logic strobe;
    strobe = !(is_d && we && (be == 4'b0000));
    if (is_d) begin
      d_req_s = 1'b1; d_we_s = we; d_addr_s = addr; d_wdata_s = wdata; d_be_s = be;
    end else begin
      if_req_s = 1'b1; if_addr_s = addr;
    end
    mem_rdata_s = 32'hBAD0_0BAD;
    @(negedge clk_s);
    chk("ready", is_d ? d_ready_s : if_ready_s, 32'd1);
    chk("other_ready", is_d ? if_ready_s : d_ready_s, 32'd0);
    tick();
    if_req_s = 1'b0; d_req_s = 1'b0;
    d_addr_s = 32'hFFFF_FFFF; d_wdata_s = 32'h5555_AAAA; d_be_s = 4'b1010; if_addr_s = 32'hFFFF_FFFF;
    for (int c = 1; c <= resp_cyc + 1; c++) begin
      @(negedge clk_s);
      chk("re_n", re_n_s, (strobe && !we && c == 1) ? 32'd0 : 32'd1);
      chk("we_n", we_n_s, (strobe && we && c == 1) ? 32'd0 : 32'd1);
      chk("rvalid", is_d ? d_rvalid_s : if_rvalid_s, (c == resp_cyc) ? 32'd1 : 32'd0);
      chk("other_rvalid", is_d ? if_rvalid_s : d_rvalid_s, 32'd0);
      chk("ready_busy", {31'd0, if_ready_s | d_ready_s}, 32'd0);
      if (c == 1 || c == resp_cyc) begin
        chk("addr", {12'd0, mem_addr_s}, {12'd0, exp_addr});
        chk("be_n", {28'd0, mem_be_n_s}, {28'd0, exp_be_n});
        if (we) chk("wdata", mem_wdata_s, wdata);
      end
      if (c == resp_cyc) chk("rdata", is_d ? d_rdata_s : if_rdata_s, we ? 32'd0 : rdata);
      if (c == resp_cyc - 1 && !we) mem_rdata_s = rdata;
      tick();
      mem_rdata_s = 32'hBAD0_0BAD;
    end
  endtask

  int          n_gnt;
  int          n_both;
  logic [3:0]  gnt_seq;

  initial begin
    rst_n_s = 1'b0;
    if_req_s = 1'b0; d_req_s = 1'b0; d_we_s = 1'b0;
    if_addr_s = 32'h0; d_addr_s = 32'h0; d_wdata_s = 32'h0; d_be_s = 4'b0000;
    mem_rdata_s = 32'hBAD0_0BAD;
    b_if_req_s = 1'b0; b_if_addr_s = 32'h0; b_mem_rdata_s = 32'hCAFE_F00D;
    #12;
    chk("rst_re_n", re_n_s, 32'd1);
    chk("rst_we_n", we_n_s, 32'd1);
    chk("rst_addr", {12'd0, mem_addr_s}, 32'd0);
    chk("rst_wdata", mem_wdata_s, 32'd0);
    chk("rst_be_n", {28'd0, mem_be_n_s}, 32'hF);
    chk("rst_rvalid", {30'd0, if_rvalid_s, d_rvalid_s}, 32'd0);
    chk("rst_rdata", if_rdata_s | d_rdata_s, 32'd0);
    chk("rst_ready", {30'd0, if_ready_s, d_ready_s}, 32'd0);
    tick();
    rst_n_s = 1'b1;
    tick();

    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 20'h00004, 4'h0, 32'h1234_5678, 5);
    run_txn(1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 20'h00041, 4'b1100, 32'h0, 4);
    run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0102_0304, 4'b0000, 20'h00080, 4'b1111, 32'h0, 1);
    run_txn(1'b1, 1'b0, 32'hABCD_1237, 32'h0, 4'hF, 20'h3448D, 4'h0, 32'h0BAD_F00D, 5);

    // reset during WAIT of a fetch read, then reset during ISSUE of a write
    if_req_s = 1'b1; if_addr_s = 32'h0000_0020;
    tick(); if_req_s = 1'b0;
    tick(); tick();
    #2 rst_n_s = 1'b0;
    #1;
    chk("midrst_re_n", re_n_s, 32'd1);
    chk("midrst_rvalid", {31'd0, if_rvalid_s}, 32'd0);
    chk("midrst_addr", {12'd0, mem_addr_s}, 32'd0);
    chk("midrst_be_n", {28'd0, mem_be_n_s}, 32'hF);
    tick(); rst_n_s = 1'b1;
    d_req_s = 1'b1; d_we_s = 1'b1; d_addr_s = 32'h0000_0008; d_wdata_s = 32'h1; d_be_s = 4'b1111;
    tick(); d_req_s = 1'b0;
    #2 rst_n_s = 1'b0;
    #1;
    chk("issue_rst_we_n", we_n_s, 32'd1);
    chk("issue_rst_wdata", mem_wdata_s, 32'd0);
    tick(); rst_n_s = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_s);
      chk("after_rst_rvalid", {30'd0, if_rvalid_s, d_rvalid_s}, 32'd0);
      tick();
    end
    run_txn(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 20'h00011, 4'h0, 32'h7777_0001, 5);

    // continuous contention from a fresh reset
    rst_n_s = 1'b0; tick(); rst_n_s = 1'b1;
    if_req_s = 1'b1; if_addr_s = 32'h0000_0080;
    d_req_s = 1'b1; d_we_s = 1'b0; d_addr_s = 32'h0000_0040; d_be_s = 4'b1111;
    n_gnt = 0; n_both = 0; gnt_seq = 4'b0000;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      @(negedge clk_s);
      if (if_ready_s && d_ready_s) n_both++;
      if (if_ready_s || d_ready_s) begin
        gnt_seq[n_gnt] = d_ready_s;
        n_gnt++;
      end
      tick();
    end
    if_req_s = 1'b0; d_req_s = 1'b0;
    chk("rr_count", n_gnt, 32'd4);
    chk("rr_both", n_both, 32'd0);
    chk("rr_order", {28'd0, gnt_seq}, 32'b1010);
    for (int c = 0; c < 8; c++) tick();

    // RD_LAT = 1 instance: response in cycle 3, held next request accepted in cycle 4
    b_if_req_s = 1'b1; b_if_addr_s = 32'h0000_0008;
    @(negedge clk_s);
    chk("fast_ready0", {31'd0, b_if_ready_s}, 32'd1);
    tick();
    b_if_addr_s = 32'h0000_000C;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_s);
      chk("fast_re_n", b_re_n_s, (c == 1) ? 32'd0 : 32'd1);
      chk("fast_rvalid", {31'd0, b_if_rvalid_s}, (c == 3) ? 32'd1 : 32'd0);
      chk("fast_ready", {31'd0, b_if_ready_s}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 1) chk("fast_addr", {12'd0, b_mem_addr_s}, 32'h2);
      if (c == 3) chk("fast_rdata", b_if_rdata_s, 32'hCAFE_F00D);
      tick();
    end
    b_if_req_s = 1'b0;
    @(negedge clk_s);
    chk("fast_addr2", {12'd0, b_mem_addr_s}, 32'h3);
    for (int c = 0; c < 6; c++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_req_arb.md
# sram_req_arb

Two-port request arbiter and sequencer sitting directly upstream of the BaseRAM SRAM controller. It accepts word requests from the instruction-fetch port and the load/store port and serialises them into single-cycle active-low read/write strobes. After a fixed, parameterised latency it captures the controller's read data and returns a one-cycle response to the originating port. It is the only driver of the SRAM controller's CPU-side inputs.

## Interface
- RD_LAT, 3: cycles spent in WAIT for a read; `mem_rdata_i` is sampled on the last WAIT edge. Must be ≥ 1.
- WR_LAT, 2: cycles spent in WAIT for a write. Must be ≥ 1.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- if_req_i  in  1  instruction-fetch read request; held with its address until accepted.
- if_addr_i  in  32  fetch byte address.
- if_ready_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  one-cycle fetch response.
- if_rdata_o  out  32  fetch data; valid only with `if_rvalid_o`.
- d_req_i  in  1  data request; held with its payload until accepted.
- d_we_i  in  1  data request type: 1 = write, 0 = read.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  write data.
- d_be_i  in  4  byte enables, active-high.
- d_ready_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  one-cycle data response; read data or write acknowledge.
- d_rdata_o  out  32  data read result; 0 for a write acknowledge.
- mem_re_n_o  out  1  read strobe to the SRAM controller, active-low.
- mem_we_n_o  out  1  write strobe to the SRAM controller, active-low.
- mem_addr_o  out  20  word address, equal to byte address bits [21:2].
- mem_wdata_o  out  32  write data.
- mem_be_n_o  out  4  byte enables, active-low (`~d_be_i`); 4'b0000 for reads.
- mem_rdata_i  in  32  read data from the SRAM controller.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any request is pending, the arbiter picks a winner and raises that port's ready, combinationally, in the same cycle.
  - On that edge the block latches the port ID, type, address, wdata and be.
  - Next state: ISSUE.
  - Special case: a data write with `d_be_i == 0` is accepted but goes straight to RESP. No strobe is issued.
- ISSUE: drive exactly one of `mem_re_n_o`/`mem_we_n_o` low for exactly one cycle. Load the counter with RD_LAT or WR_LAT. Next state: WAIT.
- WAIT
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - On a read, `mem_rdata_i` is captured into the response register on that same edge.
- RESP: pulse the owning port's rvalid with the registered data for one cycle, then return to IDLE.
- Arbitration
  - With a single request pending, that request wins.
  - With both pending, the port that did not win last time wins (round-robin).
  - The last-winner flag resets to "data", so the fetch port wins the first simultaneous contention.
- Address handling
  - Bits [1:0] are ignored; misaligned accesses are silently word-aligned.
  - Bits [31:22] are ignored; no address decode is done here.
- Payload stability: `mem_addr_o`, `mem_wdata_o` and `mem_be_n_o` stay at their latched values from ISSUE through RESP and until the next acceptance.
- Withdrawn requests: a requester that drops its request before ready sees no effect.
- No new request is accepted outside IDLE; both ready outputs are 0 there.

## Timing
- Accept edge at the end of cycle 0. Then:
  - Cycle 1: ISSUE.
  - Cycles 2 .. 1+LAT: WAIT.
  - Cycle 2+LAT: RESP, rvalid high.
- Earliest next acceptance: cycle 3+LAT.
- With defaults: read response in cycle 5, write acknowledge in cycle 4.
- Zero-be write: acknowledge in cycle 1.
- Reset values:
  - All ready and rvalid outputs 0; both rdata outputs 0.
  - `mem_re_n_o` = `mem_we_n_o` = 1.
  - `mem_addr_o` = 0, `mem_wdata_o` = 0, `mem_be_n_o` = 4'b1111.
  - State IDLE, counter 0, last-winner flag = data.
- Reset mid-operation: every output goes to its reset value immediately (asynchronous). The in-flight transaction is dropped with no rvalid. Requesters must re-issue.
- At most one strobe is low in any cycle, and never for two consecutive cycles.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state enum;
  - the port-ID type (IF/D);
  - the default RD_LAT/WR_LAT constants;
  - the SRAM word-address width (20).
- One sub-module, `rr_arb2`: a two-requester round-robin arbiter with a last-winner register. Inputs: the two requests and a grant-accept pulse. Outputs: a one-hot grant.

## Test plan
- Fetch read of 0x0000_0010 with `mem_rdata_i` = 0x1234_5678 present at the WAIT sample edge → `mem_addr_o` = 0x00004, `mem_re_n_o` low only in cycle 1, `if_rvalid_o` in cycle 5 with 0x1234_5678.
- Data write to 0x0000_0104, wdata 0xDEADBEEF, be 4'b0011 → `mem_we_n_o` low one cycle, `mem_addr_o` = 0x00041, `mem_be_n_o` = 4'b1100, `d_rvalid_o` in cycle 4 with `d_rdata_o` = 0.
- Both ports requesting continuously from reset → grants alternate IF, D, IF, D. `if_ready_o` and `d_ready_o` are never high together.
- Data write with be = 0 → no strobe, `d_rvalid_o` in cycle 1.
- `rst_ni` asserted during WAIT of a read → strobes high and rvalid 0 immediately. After release, the next request completes normally.
- RD_LAT = 1 build → read response in cycle 3, and the next request is accepted in cycle 4.
